// File: rtl/kfpcjr_bus_pkg.sv
// Shared bus-controller types: CPU status codes, controller states and the
// status -> command decode used to pick which strobe a bus cycle drives.
package kfpcjr_bus_pkg;

  typedef enum logic [2:0] {
    BS_INTA    = 3'b000,
    BS_IOR     = 3'b001,
    BS_IOW     = 3'b010,
    BS_HALT    = 3'b011,
    BS_CODE    = 3'b100,
    BS_MRDC    = 3'b101,
    BS_MWTC    = 3'b110,
    BS_PASSIVE = 3'b111
  } bus_status_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_T1,
    ST_TC,
    ST_HALT
  } bus_state_t;

  // Active-high one-hot command set; outputs invert these.
  typedef struct packed {
    logic inta;
    logic iorc;
    logic iowc;
    logic mrdc;
    logic mwtc;
  } bus_cmd_t;

  function automatic bus_cmd_t decode_cmd(input bus_status_t s);
    bus_cmd_t c;
    c = '0;
    case (s)
      BS_INTA:          c.inta = 1'b1;
      BS_IOR:           c.iorc = 1'b1;
      BS_IOW:           c.iowc = 1'b1;
      BS_CODE, BS_MRDC: c.mrdc = 1'b1;
      BS_MWTC:          c.mwtc = 1'b1;
      default:          c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_write(input bus_status_t s);
    return (s == BS_IOW) || (s == BS_MWTC);
  endfunction

  function automatic logic is_io(input bus_status_t s);
    return (s == BS_INTA) || (s == BS_IOR) || (s == BS_IOW);
  endfunction

endpackage

// File: rtl/bus_controller.sv
// 8288-style bus controller. Tracks CPU status on CPU clock edge strobes and
// generates ALE, data transceiver controls and active-low bus commands.
// Ports:
//   clock, reset_n                     system clock, async active-low reset
//   cpu_clock_posedge/negedge          one-clock CPU clock edge strobes
//   S_N[2:0]                           CPU status (111 = passive)
//   AEN_N                              high = bus granted away, commands off
//   ALE, DT_R, DEN_N, IO_OR_M          latch/transceiver controls
//   MRDC_N, MWTC_N, IORC_N, IOWC_N, INTA_N   active-low commands
module bus_controller
  import kfpcjr_bus_pkg::*;
#(
  parameter bit ADVANCED_WRITE = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cpu_clock_posedge,
  input  logic       cpu_clock_negedge,
  input  logic [2:0] S_N,
  input  logic       AEN_N,
  output logic       ALE,
  output logic       DT_R,
  output logic       DEN_N,
  output logic       IO_OR_M,
  output logic       MRDC_N,
  output logic       MWTC_N,
  output logic       IORC_N,
  output logic       IOWC_N,
  output logic       INTA_N
);

  bus_state_t  state, state_nxt;
  bus_status_t status;
  bus_status_t cyc_type, cyc_type_nxt;
  logic        prev_passive, prev_passive_nxt;
  logic        ale_r, ale_nxt;
  logic        den_r, den_nxt;
  bus_cmd_t    cmd_r, cmd_nxt;
  bus_cmd_t    type_cmd;
  logic        dtr_nxt, io_nxt;
  logic        bus_en;

  assign status = bus_status_t'(S_N);
  assign bus_en = ~AEN_N;

  always_comb begin
    state_nxt        = state;
    cyc_type_nxt     = cyc_type;
    prev_passive_nxt = prev_passive;
    ale_nxt          = ale_r;
    den_nxt          = den_r;
    cmd_nxt          = cmd_r;
    dtr_nxt          = DT_R;
    io_nxt           = IO_OR_M;
    type_cmd         = decode_cmd(cyc_type);

    if (cpu_clock_posedge) begin
      // A cycle starts only on a passive -> active status transition, so a
      // status held across reset or across the end of TC cannot retrigger.
      prev_passive_nxt = (status == BS_PASSIVE);
      case (state)
        ST_IDLE: begin
          if (prev_passive) begin
            if (status == BS_HALT) begin
              state_nxt = ST_HALT;
            end else if (status != BS_PASSIVE) begin
              state_nxt    = ST_T1;
              cyc_type_nxt = status;
              ale_nxt      = 1'b1;
              dtr_nxt      = is_write(status);
              io_nxt       = is_io(status);
            end
          end
        end
        ST_T1: begin
          ale_nxt = 1'b0;
          if (status == BS_PASSIVE) begin
            state_nxt = ST_IDLE;
            cmd_nxt   = '0;
            dtr_nxt   = 1'b1;
            io_nxt    = 1'b0;
          end else begin
            state_nxt = ST_TC;
            cmd_nxt   = type_cmd;
            den_nxt   = 1'b1;
          end
        end
        ST_TC: begin
          if (status == BS_PASSIVE) begin
            state_nxt = ST_IDLE;
            cmd_nxt   = '0;
            den_nxt   = 1'b0;
            dtr_nxt   = 1'b1;
            io_nxt    = 1'b0;
          end
        end
        ST_HALT: begin
          if (status == BS_PASSIVE) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (cpu_clock_negedge && (state == ST_T1)) begin
      ale_nxt = 1'b0;
      if (ADVANCED_WRITE) begin
        cmd_nxt.iowc = type_cmd.iowc;
        cmd_nxt.mwtc = type_cmd.mwtc;
      end
    end
  end

  // Internal *_r registers track the cycle regardless of AEN_N; the output
  // registers are loaded from the same next values gated by the bus grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cyc_type     <= BS_PASSIVE;
      prev_passive <= 1'b0;
      ale_r        <= 1'b0;
      den_r        <= 1'b0;
      cmd_r        <= '0;
      DT_R         <= 1'b1;
      IO_OR_M      <= 1'b0;
      ALE          <= 1'b0;
      DEN_N        <= 1'b1;
      MRDC_N       <= 1'b1;
      MWTC_N       <= 1'b1;
      IORC_N       <= 1'b1;
      IOWC_N       <= 1'b1;
      INTA_N       <= 1'b1;
    end else begin
      state        <= state_nxt;
      cyc_type     <= cyc_type_nxt;
      prev_passive <= prev_passive_nxt;
      ale_r        <= ale_nxt;
      den_r        <= den_nxt;
      cmd_r        <= cmd_nxt;
      DT_R         <= dtr_nxt;
      IO_OR_M      <= io_nxt;
      ALE          <= ale_nxt & bus_en;
      DEN_N        <= ~(den_nxt & bus_en);
      MRDC_N       <= ~(cmd_nxt.mrdc & bus_en);
      MWTC_N       <= ~(cmd_nxt.mwtc & bus_en);
      IORC_N       <= ~(cmd_nxt.iorc & bus_en);
      IOWC_N       <= ~(cmd_nxt.iowc & bus_en);
      INTA_N       <= ~(cmd_nxt.inta & bus_en);
    end
  end

endmodule
